// File: rtl/sprite_scheduler.sv
// Per-line sprite scheduler: scans the object table during one line and commits
// up to NUM_SLOTS covering objects (lowest index first) to the engine slots at the next line pulse.
module sprite_scheduler #(
    parameter int CORDW     = 16,
    parameter int NUM_OBJ   = 16,
    parameter int NUM_SLOTS = 4,
    parameter int OBJ_H     = 16,
    parameter int V_RES     = 480,
    parameter int PARK_Y    = 2**(CORDW-1)-1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           line,
    input  logic signed [CORDW-1:0]        sy,
    input  logic                           obj_we,
    input  logic [$clog2(NUM_OBJ)-1:0]     obj_addr,
    input  logic                           obj_en,
    input  logic signed [CORDW-1:0]        obj_x,
    input  logic signed [CORDW-1:0]        obj_y,
    output logic [NUM_SLOTS*CORDW-1:0]     slot_x,
    output logic [NUM_SLOTS*CORDW-1:0]     slot_y,
    output logic [NUM_SLOTS-1:0]           slot_valid,
    output logic                           overflow,
    output logic                           late,
    output logic                           busy
);
    localparam int IDXW = $clog2(NUM_OBJ);
    localparam int CNTW = $clog2(NUM_SLOTS+1);
    localparam logic signed [CORDW-1:0] PARK     = CORDW'(PARK_Y);
    localparam logic [IDXW-1:0]         LAST_IDX = IDXW'(NUM_OBJ-1);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t                   state_reg, state_next;
    logic [IDXW-1:0]          idx_reg;
    logic [CNTW-1:0]          count_reg;
    logic signed [CORDW-1:0]  next_y_reg;
    logic                     sh_ovf_reg;
    logic                     overflow_reg;
    logic                     late_reg;

    logic                     tab_en [NUM_OBJ];
    logic signed [CORDW-1:0]  tab_x  [NUM_OBJ];
    logic signed [CORDW-1:0]  tab_y  [NUM_OBJ];

    logic signed [CORDW-1:0]  sy_inc;
    logic signed [CORDW-1:0]  d;
    logic                     scan_step;
    logic                     hit;
    logic                     slot_free;

    // Object table: each entry owns its registers; read combinationally by idx.
    generate
        for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
            logic                    en_reg;
            logic signed [CORDW-1:0] x_reg;
            logic signed [CORDW-1:0] y_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    en_reg <= 1'b0;
                end else if (obj_we && obj_addr == IDXW'(gi)) begin
                    en_reg <= obj_en;
                    x_reg  <= obj_x;
                    y_reg  <= obj_y;
                end
            end

            assign tab_en[gi] = en_reg;
            assign tab_x[gi]  = x_reg;
            assign tab_y[gi]  = y_reg;
        end
    endgenerate

    // A line pulse pre-empts the scan step of that cycle.
    always_comb begin
        sy_inc    = sy + CORDW'(1);
        d         = next_y_reg - tab_y[idx_reg];
        scan_step = (state_reg == SCAN) && !line;
        hit       = scan_step && tab_en[idx_reg] && !d[CORDW-1] && (d < CORDW'(OBJ_H));
        slot_free = count_reg < CNTW'(NUM_SLOTS);
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (line)
            state_next = SCAN;
        else if (state_reg == SCAN && idx_reg == LAST_IDX)
            state_next = IDLE;
    end

    always_comb begin
        busy = (state_reg == SCAN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg      <= '0;
            count_reg    <= '0;
            next_y_reg   <= '0;
            sh_ovf_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            late_reg     <= 1'b0;
        end else if (line) begin
            overflow_reg <= sh_ovf_reg;
            late_reg     <= (state_reg == SCAN);
            next_y_reg   <= (sy_inc == CORDW'(V_RES)) ? '0 : sy_inc;
            count_reg    <= '0;
            sh_ovf_reg   <= 1'b0;
            idx_reg      <= '0;
        end else if (scan_step) begin
            idx_reg <= idx_reg + 1'b1;
            if (hit) begin
                if (slot_free) count_reg  <= count_reg + 1'b1;
                else           sh_ovf_reg <= 1'b1;
            end
        end
    end

    // Per-slot shadow and committed output registers.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            logic signed [CORDW-1:0] sh_x_reg, sh_y_reg, out_x_reg, out_y_reg;
            logic                    sh_v_reg, out_v_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sh_x_reg  <= '0;
                    sh_y_reg  <= PARK;
                    sh_v_reg  <= 1'b0;
                    out_x_reg <= '0;
                    out_y_reg <= PARK;
                    out_v_reg <= 1'b0;
                end else if (line) begin
                    out_x_reg <= sh_x_reg;
                    out_y_reg <= sh_y_reg;
                    out_v_reg <= sh_v_reg;
                    sh_y_reg  <= PARK;
                    sh_v_reg  <= 1'b0;
                end else if (hit && slot_free && count_reg == CNTW'(gi)) begin
                    sh_x_reg <= tab_x[idx_reg];
                    sh_y_reg <= tab_y[idx_reg];
                    sh_v_reg <= 1'b1;
                end
            end

            assign slot_x[gi*CORDW +: CORDW] = out_x_reg;
            assign slot_y[gi*CORDW +: CORDW] = out_y_reg;
            assign slot_valid[gi]            = out_v_reg;
        end
    endgenerate

    assign overflow = overflow_reg;
    assign late     = late_reg;

endmodule

// File: tb/tb_sprite_scheduler.sv
// Bench for sprite_scheduler: a per-line snapshot model (filter covering objects, keep the first
// NUM_SLOTS) checked every cycle, plus directed scenarios with literal expectations.
module tb_sprite_scheduler;
    localparam int CW   = 16;
    localparam int NO   = 16;
    localparam int NS   = 4;
    localparam int OH   = 16;
    localparam int VR   = 480;
    localparam int PARK = 32767;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 line = 1'b0;
    logic signed [CW-1:0] sy = '0;
    logic                 obj_we = 1'b0;
    logic [3:0]           obj_addr = '0;
    logic                 obj_en = 1'b0;
    logic signed [CW-1:0] obj_x = '0;
    logic signed [CW-1:0] obj_y = '0;
    logic [NS*CW-1:0]     slot_x, slot_y;
    logic [NS-1:0]        slot_valid;
    logic                 overflow, late, busy;

    sprite_scheduler #(
        .CORDW(CW), .NUM_OBJ(NO), .NUM_SLOTS(NS), .OBJ_H(OH), .V_RES(VR), .PARK_Y(PARK)
    ) dut (
        .clk(clk), .rst(rst), .line(line), .sy(sy),
        .obj_we(obj_we), .obj_addr(obj_addr), .obj_en(obj_en), .obj_x(obj_x), .obj_y(obj_y),
        .slot_x(slot_x), .slot_y(slot_y), .slot_valid(slot_valid),
        .overflow(overflow), .late(late), .busy(busy)
    );

    always #5 clk = ~clk;

    // model: live table, per-line snapshots of what the scan has looked at, expected outputs
    bit m_en[NO];
    int m_x[NO], m_y[NO];
    bit s_done[NO], s_en[NO];
    int s_x[NO], s_y[NO];
    bit m_scan;
    int m_pos, m_ny;
    int e_x[NS], e_y[NS];
    bit e_v[NS];
    bit e_ovf, e_late, e_busy;

    int checks = 0, errors = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit covers(input int ny, input int y);
        int dd;
        dd = ny - y;
        return (dd >= 0) && (dd < OH);
    endfunction

    task automatic model_edge();
        int n;
        if (rst) begin
            for (int i = 0; i < NO; i++) begin m_en[i] = 0; s_done[i] = 0; end
            for (int k = 0; k < NS; k++) begin e_x[k] = 0; e_y[k] = PARK; e_v[k] = 0; end
            e_ovf = 0; e_late = 0; m_scan = 0; m_pos = 0; m_ny = 0;
        end else begin
            if (!line && m_scan) begin
                s_done[m_pos] = 1; s_en[m_pos] = m_en[m_pos];
                s_x[m_pos] = m_x[m_pos]; s_y[m_pos] = m_y[m_pos];
                m_pos++;
                if (m_pos == NO) m_scan = 0;
            end
            if (line) begin
                n = 0; e_ovf = 0;
                for (int k = 0; k < NS; k++) begin e_v[k] = 0; e_y[k] = PARK; end
                for (int i = 0; i < NO; i++) begin
                    if (s_done[i] && s_en[i] && covers(m_ny, s_y[i])) begin
                        if (n < NS) begin
                            e_x[n] = s_x[i]; e_y[n] = s_y[i]; e_v[n] = 1; n++;
                        end else e_ovf = 1;
                    end
                end
                e_late = m_scan;
                m_scan = 1; m_pos = 0;
                for (int i = 0; i < NO; i++) s_done[i] = 0;
                m_ny = (int'(sy) + 1 == VR) ? 0 : int'(sy) + 1;
            end
            if (obj_we) begin
                m_en[obj_addr] = obj_en; m_x[obj_addr] = int'(obj_x); m_y[obj_addr] = int'(obj_y);
            end
        end
        e_busy = m_scan;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < NS; k++) begin
                check($sformatf("slot_valid[%0d]", k), int'(slot_valid[k]), int'(e_v[k]));
                check($sformatf("slot_y[%0d]", k), int'($signed(slot_y[k*CW +: CW])), e_y[k]);
                if (e_v[k])
                    check($sformatf("slot_x[%0d]", k), int'($signed(slot_x[k*CW +: CW])), e_x[k]);
            end
            check("overflow", int'(overflow), int'(e_ovf));
            check("late", int'(late), int'(e_late));
            check("busy", int'(busy), int'(e_busy));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input int s);
        sy = CW'(s); line = 1'b1;
        tick();
        line = 1'b0;
    endtask

    task automatic wr(input int a, input bit en, input int x, input int y);
        obj_we = 1'b1; obj_addr = 4'(a); obj_en = en; obj_x = CW'(x); obj_y = CW'(y);
        tick();
        obj_we = 1'b0;
    endtask

    task automatic clear_table();
        for (int i = 0; i < NO; i++) wr(i, 0, 0, 0);
    endtask

    function automatic int sx(input int k);
        return int'($signed(slot_x[k*CW +: CW]));
    endfunction

    function automatic int sy_of(input int k);
        return int'($signed(slot_y[k*CW +: CW]));
    endfunction

    initial begin
        int period, cnt;

        rst = 1'b1;
        tick();
        chk_on = 1'b1;
        idle(2);
        rst = 1'b0;
        tick();
        check("lit_reset_valid", int'(slot_valid), 0);
        check("lit_reset_busy", int'(busy), 0);
        for (int k = 0; k < NS; k++) begin
            check("lit_reset_x", sx(k), 0);
            check("lit_reset_y", sy_of(k), PARK);
        end

        // empty table
        pulse(0); idle(20); pulse(0); idle(2);
        check("lit_empty_valid", int'(slot_valid), 0);
        check("lit_empty_ovf", int'(overflow), 0);
        check("lit_empty_late", int'(late), 0);
        for (int k = 0; k < NS; k++) check("lit_empty_y", sy_of(k), PARK);

        // index order, not position order
        wr(3, 1, 100, 50); wr(1, 1, 20, 52);
        pulse(52); idle(20); pulse(53); idle(1);
        check("lit_order_valid", int'(slot_valid), 4'b0011);
        check("lit_order_x0", sx(0), 20);
        check("lit_order_y0", sy_of(0), 52);
        check("lit_order_x1", sx(1), 100);
        check("lit_order_y1", sy_of(1), 50);

        // overflow
        clear_table();
        for (int i = 0; i < 6; i++) wr(i, 1, i * 10 + 5, 10);
        pulse(9); idle(20); pulse(10); idle(1);
        check("lit_ovf_valid", int'(slot_valid), 4'b1111);
        check("lit_ovf_flag", int'(overflow), 1);
        for (int k = 0; k < NS; k++) check("lit_ovf_x", sx(k), k * 10 + 5);

        // next_y wrap and height boundary
        clear_table();
        wr(0, 1, 5, 0); wr(1, 1, 6, -15); wr(2, 1, 7, -16);
        pulse(VR - 1); idle(20); pulse(0); idle(1);
        check("lit_wrap_valid", int'(slot_valid), 4'b0011);
        check("lit_wrap_y0", sy_of(0), 0);
        check("lit_wrap_y1", sy_of(1), -15);
        check("lit_wrap_ovf", int'(overflow), 0);

        // short line period
        clear_table();
        for (int i = 6; i < NO; i++) wr(i, 1, 200 + i, 100);
        pulse(99); idle(20);
        for (int r = 0; r < 3; r++) begin pulse(99); idle(NO/2 - 1); end
        pulse(99); idle(1);
        check("lit_late_flag", int'(late), 1);
        check("lit_late_valid", int'(slot_valid), 4'b0001);
        check("lit_late_x0", sx(0), 206);

        // reset and line together mid-scan
        pulse(99); idle(5);
        rst = 1'b1; line = 1'b1;
        tick();
        rst = 1'b0; line = 1'b0;
        check("lit_rst_busy", int'(busy), 0);
        check("lit_rst_valid", int'(slot_valid), 0);
        check("lit_rst_late", int'(late), 0);
        check("lit_rst_ovf", int'(overflow), 0);
        for (int k = 0; k < NS; k++) check("lit_rst_y", sy_of(k), PARK);
        idle(2);

        // randomized traffic
        period = 20; cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            obj_we   = ($urandom_range(0, 3) == 0);
            obj_addr = 4'($urandom_range(0, NO - 1));
            obj_en   = ($urandom_range(0, 3) != 0);
            obj_x    = CW'($urandom_range(0, 639));
            obj_y    = CW'(int'($urandom_range(0, 100)) - 20);
            cnt++;
            if (cnt >= period) begin
                line = 1'b1;
                sy = ($urandom_range(0, 9) == 0) ? CW'(VR - 1) : CW'($urandom_range(0, 80));
                period = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 16)) : int'($urandom_range(17, 30));
                cnt = 0;
            end
            rst = ($urandom_range(0, 999) == 0);
            tick();
            line = 1'b0; rst = 1'b0; obj_we = 1'b0;
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
